rej_ntt_poly: RTL and testbench

Rejection sampler that turns the SHAKE128 squeeze stream into one uniform NTT-domain polynomial with coefficients in [0, Q). It consumes 64-bit squeeze words and extracts 3-byte candidates. Each candidate is masked to 23 bits and kept only if it is below Q; sampling stops after N coefficients. ExpandA instantiates one of these per matrix entry A[i][j], directly downstream of the SHAKE128 core.

---
 rtl/rej_ntt_poly.sv | 107 ++++++++++
 tb/tb_rej_ntt_poly.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rej_ntt_poly.sv
// Rejection sampler: 64-bit squeeze words -> 3-byte candidates masked to 23 bits, kept if below Q, until N coefficients.
// One action per RUN cycle (load word or test a candidate); done pulses the cycle after the N-th coefficient is written.
module rej_ntt_poly #(
    parameter int N            = 256,
    parameter int COEFF_WIDTH  = 24,
    parameter int DATA_IN_BITS = 64,
    parameter int Q            = 8380417
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    input  logic [DATA_IN_BITS-1:0]     data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        done,
    output logic [COEFF_WIDTH*N-1:0]    poly
);

    localparam int WORD_BYTES = DATA_IN_BITS / 8;
    localparam int BUF_BITS   = DATA_IN_BITS + 16;
    localparam int BCW        = $clog2(WORD_BYTES + 3);
    localparam int CCW        = $clog2(N + 1);
    localparam logic [23:0] QV = 24'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                      r_state;
    logic [BUF_BITS-1:0]         r_buf;
    logic [BCW-1:0]              r_byte_cnt;
    logic [CCW-1:0]              r_coeff_cnt;
    logic                        r_busy;
    logic                        r_done;
    logic [COEFF_WIDTH*N-1:0]    r_poly;

    logic                        w_rdy;
    logic                        w_have_cand;
    logic [22:0]                 w_cand;
    logic                        w_accept;
    logic                        w_last;
    logic [BUF_BITS-1:0]         w_word_shifted;

    // A word is only taken with fewer than 3 bytes buffered, so 2 leftover bytes + 8 new always fit in 80 bits.
    assign w_rdy          = (r_state == S_RUN) && (r_byte_cnt < BCW'(3));
    assign w_have_cand    = (r_byte_cnt >= BCW'(3));
    assign w_cand         = r_buf[22:0];
    assign w_accept       = ({1'b0, w_cand} < QV);
    assign w_last         = (r_coeff_cnt == CCW'(N - 1));
    assign w_word_shifted = BUF_BITS'(data_in) << {r_byte_cnt, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_byte_cnt  <= '0;
            r_coeff_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_poly      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_buf       <= '0;
                        r_byte_cnt  <= '0;
                        r_coeff_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (data_in_valid && w_rdy) begin
                        r_buf      <= r_buf | w_word_shifted;
                        r_byte_cnt <= r_byte_cnt + BCW'(WORD_BYTES);
                    end else if (w_have_cand) begin
                        r_buf      <= r_buf >> 24;
                        r_byte_cnt <= r_byte_cnt - BCW'(3);
                        if (w_accept) begin
                            r_poly[r_coeff_cnt*COEFF_WIDTH +: COEFF_WIDTH] <= COEFF_WIDTH'(w_cand);
                            r_coeff_cnt <= r_coeff_cnt + 1'b1;
                            if (w_last) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_in_ready = w_rdy;
    assign busy          = r_busy;
    assign done          = r_done;
    assign poly          = r_poly;

endmodule

// File: tb/tb_rej_ntt_poly.sv
// Scoreboard bench for rej_ntt_poly: byte-stream reference model, decoupled driver, stimulus and done monitor.
module tb_rej_ntt_poly;
    localparam int N  = 256;
    localparam int CW = 24;
    localparam int Q  = 8380417;
    localparam int PW = N * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, data_in_ready, done;
    logic          data_in_valid;
    logic [63:0]   data_in;
    logic [PW-1:0] poly;

    always #5 clk = ~clk;

    rej_ntt_poly dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .done(done), .poly(poly)
    );

    typedef struct packed {
        logic [PW-1:0] p;
        int            words;
        int            lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] stream[$];
    int  total = 0, bad = 0;
    int  cyc = 0, t_start = 0, ndone = 0, nwords = 0;
    bit  bubbles = 1'b0;
    bit  rdy_chk_next = 1'b0;

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    function automatic logic [7:0] sbyte(input int i);
        logic [63:0] w;
        w = (i / 8 < stream.size()) ? stream[i / 8] : 64'h0;
        return w[8 * (i % 8) +: 8];
    endfunction

    function automatic logic [23:0] coef(input int j);
        return poly[j * CW +: CW];
    endfunction

    // Walk the byte stream 3 bytes at a time; every candidate (accepted or not) costs one cycle, every word one cycle.
    task automatic model(output exp_t e);
        int acc, k, cv;
        e.p = '0;
        acc = 0;
        k   = 0;
        while (acc < N) begin
            cv = int'(sbyte(3 * k)) + (int'(sbyte(3 * k + 1)) << 8) + (int'(sbyte(3 * k + 2) & 8'h7F) << 16);
            if (cv < Q) begin
                e.p[acc * CW +: CW] = 24'(cv);
                acc++;
            end
            k++;
        end
        e.words = (3 * k + 7) / 8;
        e.lat   = bubbles ? -1 : e.words + k + 1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Driver: predicts handshakes at the negedge, where ready and valid are both settled.
    initial begin
        data_in       = '0;
        data_in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_chk_next && !rst)
                chk("ready_after_word", longint'(data_in_ready), 0);
            rdy_chk_next  = 1'b0;
            data_in       = (nwords < stream.size()) ? stream[nwords] : 64'h0;
            data_in_valid = bubbles ? 1'($urandom % 2) : 1'b1;
            if (data_in_valid && data_in_ready && !rst) begin
                nwords++;
                rdy_chk_next = 1'b1;
            end
        end
    end

    // Monitor: every done pops one expected poly.
    initial begin
        exp_t e;
        bit   after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                after_done = 1'b0;
            end else if (after_done) begin
                chk("done_single_pulse", longint'(done), 0);
                chk("busy_after_done", longint'(busy), 0);
                after_done = 1'b0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (poly != e.p) begin
                        bad++;
                        for (int j = 0; j < N; j++)
                            if (coef(j) != e.p[j * CW +: CW]) begin
                                $display("FAIL poly coeff %0d: got 0x%06h want 0x%06h", j, coef(j), e.p[j * CW +: CW]);
                                break;
                            end
                    end
                    chk("words_consumed", nwords, e.words);
                    chk("busy_at_done", longint'(busy), 1);
                    if (e.lat >= 0)
                        chk("start_to_done", cyc - t_start, e.lat);
                end
                ndone++;
                after_done = 1'b1;
            end
        end
    end

    task automatic begin_run(input bit push);
        exp_t e;
        model(e);
        if (push)
            exp_q.push_back(e);
        @(posedge clk);
        #1;
        nwords  = 0;
        start   = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n0 = ndone;
        int t  = 0;
        while (ndone == n0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (ndone == n0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no done want done", nm);
        end
    endtask

    task automatic set_t2_stream();
        stream.delete();
        stream.push_back(64'hFFFF7FE0017FE000);
        stream.push_back(64'h00FFE000800005FF);
    endtask

    initial begin
        int n0, t;
        logic [7:0] b;
        logic [63:0] w;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ready", longint'(data_in_ready), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_poly_zero", longint'(poly == '0), 1);

        // all-zero stream
        stream.delete();
        bubbles = 1'b0;
        begin_run(1);
        wait_done("t1");
        chk("t1_words", nwords, 96);

        // boundary bytes around Q
        set_t2_stream();
        begin_run(1);
        wait_done("t2");
        chk("t2_c0", coef(0), 24'h7FE000);
        chk("t2_c1", coef(1), 24'h000005);
        chk("t2_c2", coef(2), 24'h7FE000);
        chk("t2_c3", coef(3), 0);

        // candidate straddling two words
        stream.delete();
        stream.push_back(64'h0807060504030201);
        stream.push_back(64'h100F0E0D0C0B0A09);
        begin_run(1);
        wait_done("t3");
        chk("t3_c0", coef(0), 24'h030201);
        chk("t3_c1", coef(1), 24'h060504);
        chk("t3_c2", coef(2), 24'h090807);
        chk("t3_c3", coef(3), 24'h0C0B0A);

        // zeros with random valid bubbles
        stream.delete();
        bubbles = 1'b1;
        begin_run(1);
        wait_done("t4");
        chk("t4_poly_zero", longint'(poly == '0), 1);
        chk("t4_words", nwords, 96);
        bubbles = 1'b0;

        // start pulsed mid-run must not restart
        set_t2_stream();
        begin_run(1);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t5_ignore_start");

        // reset mid-run aborts with no done
        begin_run(0);
        t = 0;
        while (nwords < 38 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        n0  = ndone;
        rst = 1'b1;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_ready", longint'(data_in_ready), 0);
        chk("abort_poly_zero", longint'(poly == '0), 1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", ndone - n0, 0);
        begin_run(1);
        wait_done("t5_rerun");
        chk("t5_c0", coef(0), 24'h7FE000);
        chk("t5_c1", coef(1), 24'h000005);

        // 0xFF phase produces only rejections
        stream.delete();
        for (int i = 0; i < 18; i++)
            stream.push_back(64'hFFFFFFFFFFFFFFFF);
        begin_run(1);
        wait_done("t6");
        chk("t6_poly_zero", longint'(poly == '0), 1);
        chk("t6_words", nwords, 114);

        // random streams biased towards 0xFF bytes to exercise rejection
        for (int it = 0; it < 6; it++) begin
            stream.delete();
            for (int i = 0; i < 150; i++) begin
                for (int k = 0; k < 8; k++) begin
                    b = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
                    w[8 * k +: 8] = b;
                end
                stream.push_back(w);
            end
            bubbles = 1'(it % 2);
            begin_run(1);
            wait_done("rand");
        end
        bubbles = 1'b0;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
